// File: rtl/fire_control_pkg.sv
// rtl/fire_control_pkg.sv - shared types and widths for the player weapon controller
package fire_control_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        IN_FLIGHT = 2'd1,
        COOLDOWN  = 2'd2,
        RELOAD    = 2'd3
    } fc_state_t;

    localparam int AMMO_W = 4;
    localparam int Y_W    = 11;
    localparam int CNT_W  = 16;
    localparam logic [7:0] HITS_MAX = 8'd255;

    // A frame count of 0 behaves like 1, so both map to a terminal count of 0.
    function automatic logic [CNT_W-1:0] frames_terminal(input int n);
        return (n <= 1) ? '0 : CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/fire_control_if.sv
// rtl/fire_control_if.sv - keyboard, collision and missile mover signals of the weapon controller
interface fire_control_if;
    import fire_control_pkg::*;

    logic             startOfFrame;
    logic             fire_key;
    logic             reload_key;
    logic             hit;
    logic [Y_W-1:0]   missileTopLeftY;
    logic             fire;
    logic             missile_active;
    logic [AMMO_W-1:0] ammo;
    logic             reloading;
    logic [7:0]       hits_count;

    modport master (
        input  startOfFrame, fire_key, reload_key, hit, missileTopLeftY,
        output fire, missile_active, ammo, reloading, hits_count
    );

    modport slave (
        output startOfFrame, fire_key, reload_key, hit, missileTopLeftY,
        input  fire, missile_active, ammo, reloading, hits_count
    );

endinterface

// File: rtl/fire_control_frame_timer.sv
// rtl/fire_control_frame_timer.sv - counts frame pulses up to a terminal value
module frame_timer
    import fire_control_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             startOfFrame,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // done is combinational so the owning FSM leaves on the terminal pulse itself.
    assign done = startOfFrame && (count == terminal);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (startOfFrame) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fire_control.sv
// rtl/fire_control.sv - player weapon controller: launch pulses, magazine, cooldown and reload
module fire_control
    import fire_control_pkg::*;
#(
    parameter int MAGAZINE              = 8,
    parameter int COOLDOWN_FRAMES       = 6,
    parameter int RELOAD_FRAMES         = 30,
    parameter int FLIGHT_TIMEOUT_FRAMES = 64,
    parameter int TOP_LIMIT             = 5
) (
    input  logic           clk,
    input  logic           reset,
    fire_control_if.master bus
);

    localparam logic [AMMO_W-1:0] MAG     = AMMO_W'(MAGAZINE);
    localparam logic [Y_W-1:0]    Y_LIMIT = Y_W'(TOP_LIMIT);

    fc_state_t         state, state_next;
    logic              fire_d, reload_d;
    logic              first_cycle;
    logic [AMMO_W-1:0] ammo_q, ammo_next;
    logic [7:0]        hits_q, hits_next;
    logic              fire_q, fire_next;
    logic              active_q, reloading_q;
    logic [CNT_W-1:0]  terminal;
    logic              timer_done;

    wire fire_rise   = bus.fire_key & ~fire_d;
    wire reload_rise = bus.reload_key & ~reload_d;
    wire timer_clear = (state_next != state);

    frame_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (timer_clear),
        .startOfFrame (bus.startOfFrame),
        .terminal     (terminal),
        .done         (timer_done)
    );

    always_comb begin
        state_next = state;
        ammo_next  = ammo_q;
        hits_next  = hits_q;
        fire_next  = 1'b0;
        terminal   = '0;
        case (state)
            READY: begin
                if (fire_rise) begin
                    if (ammo_q != '0) begin
                        fire_next  = 1'b1;
                        ammo_next  = ammo_q - 1'b1;
                        state_next = IN_FLIGHT;
                    end else begin
                        state_next = RELOAD;
                    end
                end else if (reload_rise && (ammo_q < MAG)) begin
                    state_next = RELOAD;
                end
            end
            IN_FLIGHT: begin
                terminal = frames_terminal(FLIGHT_TIMEOUT_FRAMES);
                // The mover has not placed the missile yet on the first cycle, so Y is ignored there.
                if (bus.hit) begin
                    if (hits_q != HITS_MAX) hits_next = hits_q + 8'd1;
                    state_next = COOLDOWN;
                end else if ((!first_cycle && (bus.missileTopLeftY <= Y_LIMIT)) || timer_done) begin
                    state_next = COOLDOWN;
                end
            end
            COOLDOWN: begin
                terminal = frames_terminal(COOLDOWN_FRAMES);
                if (timer_done) state_next = (ammo_q == '0) ? RELOAD : READY;
            end
            RELOAD: begin
                terminal = frames_terminal(RELOAD_FRAMES);
                if (timer_done) begin
                    ammo_next  = MAG;
                    state_next = READY;
                end
            end
            default: state_next = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= READY;
            ammo_q      <= MAG;
            hits_q      <= '0;
            fire_q      <= 1'b0;
            active_q    <= 1'b0;
            reloading_q <= 1'b0;
            fire_d      <= 1'b0;
            reload_d    <= 1'b0;
            first_cycle <= 1'b0;
        end else begin
            state       <= state_next;
            ammo_q      <= ammo_next;
            hits_q      <= hits_next;
            fire_q      <= fire_next;
            active_q    <= (state_next == IN_FLIGHT);
            reloading_q <= (state_next == RELOAD);
            fire_d      <= bus.fire_key;
            reload_d    <= bus.reload_key;
            first_cycle <= (state != IN_FLIGHT) && (state_next == IN_FLIGHT);
        end
    end

    assign bus.fire           = fire_q;
    assign bus.missile_active = active_q;
    assign bus.ammo           = ammo_q;
    assign bus.reloading      = reloading_q;
    assign bus.hits_count     = hits_q;

endmodule

// File: tb/tb_fire_control.sv
// tb/tb_fire_control.sv - self-checking bench for fire_control
module tb_fire_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fire_control_if bus ();

    fire_control #(
        .MAGAZINE              (8),
        .COOLDOWN_FRAMES       (6),
        .RELOAD_FRAMES         (30),
        .FLIGHT_TIMEOUT_FRAMES (64),
        .TOP_LIMIT             (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        fk;
        logic        rk;
        logic        h;
        logic [10:0] y;
        logic        launch;
        logic        e_fire;
        logic        e_act;
        logic [3:0]  e_ammo;
        logic        e_rel;
        logic [7:0]  e_hits;
    } vec_t;

    vec_t       tbl[8];
    logic [3:0] shot_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         m_ammo = 8;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input logic fk, input logic rk, input logic h, input logic sof, input logic [10:0] y);
        bus.fire_key        = fk;
        bus.reload_key      = rk;
        bus.hit             = h;
        bus.startOfFrame    = sof;
        bus.missileTopLeftY = y;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n, input logic fk, input logic [10:0] y);
        for (int f = 0; f < n; f++) begin
            cyc(fk, 1'b0, 1'b0, 1'b0, y);
            cyc(fk, 1'b0, 1'b0, 1'b0, y);
            cyc(fk, 1'b0, 1'b0, 1'b0, y);
            cyc(fk, 1'b0, 1'b0, 1'b1, y);
        end
    endtask

    // Launch with a fresh rise, then release the key during the first flight cycle.
    task automatic shoot(input logic rk, input logic [10:0] y);
        m_ammo--;
        shot_q.push_back(4'(m_ammo));
        cyc(1'b1, rk, 1'b0, 1'b0, y);
        chk("shot_fire", 16'(bus.fire), 16'd1);
        chk("shot_active", 16'(bus.missile_active), 16'd1);
        chk("shot_reloading", 16'(bus.reloading), 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, y);
        chk("shot_fire_width", 16'(bus.fire), 16'd0);
        chk("shot_active_hold", 16'(bus.missile_active), 16'd1);
    endtask

    // Every launch pulse must match a launch the bench asked for, carrying the decremented ammo.
    always @(posedge clk) begin
        #1;
        if (bus.fire === 1'b1) begin
            if (shot_q.size() == 0) chk("sb_unexpected_fire", 16'd1, 16'd0);
            else chk("sb_ammo", 16'(bus.ammo), 16'(shot_q.pop_front()));
        end
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 11'd450, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 11'd450, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 11'd450, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 11'd450, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 11'd450, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 11'd450, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 11'd450, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 11'd450, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};

        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd450);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd450);
        chk("rst_fire", 16'(bus.fire), 16'd0);
        chk("rst_active", 16'(bus.missile_active), 16'd0);
        chk("rst_ammo", 16'(bus.ammo), 16'd8);
        chk("rst_reloading", 16'(bus.reloading), 16'd0);
        chk("rst_hits", 16'(bus.hits_count), 16'd0);
        reset = 1'b0;

        // Launch, held key, re-press in flight, hit, hit outside flight, reload key in cooldown.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].launch) begin
                shot_q.push_back(tbl[i].e_ammo);
                m_ammo = int'(tbl[i].e_ammo);
            end
            cyc(tbl[i].fk, tbl[i].rk, tbl[i].h, 1'b0, tbl[i].y);
            chk($sformatf("tbl%0d_fire", i), 16'(bus.fire), 16'(tbl[i].e_fire));
            chk($sformatf("tbl%0d_active", i), 16'(bus.missile_active), 16'(tbl[i].e_act));
            chk($sformatf("tbl%0d_ammo", i), 16'(bus.ammo), 16'(tbl[i].e_ammo));
            chk($sformatf("tbl%0d_reloading", i), 16'(bus.reloading), 16'(tbl[i].e_rel));
            chk($sformatf("tbl%0d_hits", i), 16'(bus.hits_count), 16'(tbl[i].e_hits));
        end

        // Rise during cooldown, still held at READY entry: no launch.
        frames(5, 1'b0, 11'd450);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 11'd450);
        frames(1, 1'b1, 11'd450);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 11'd450);
        chk("cd_held_no_fire_ammo", 16'(bus.ammo), 16'd7);
        chk("cd_held_no_fire_active", 16'(bus.missile_active), 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd450);
        shoot(1'b0, 11'd450);

        // Missile climbs off the top without a hit.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd200);
        chk("lost_still_active", 16'(bus.missile_active), 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd5);
        chk("lost_active", 16'(bus.missile_active), 16'd0);
        chk("lost_hits", 16'(bus.hits_count), 16'd1);
        frames(6, 1'b0, 11'd450);

        // Y at the limit during the first flight cycle is ignored.
        shoot(1'b0, 11'd5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd5);
        chk("first_cycle_lost", 16'(bus.missile_active), 16'd0);
        frames(6, 1'b0, 11'd450);

        // Hit and lost together count once.
        shoot(1'b0, 11'd450);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 11'd5);
        chk("hitlost_active", 16'(bus.missile_active), 16'd0);
        chk("hitlost_hits", 16'(bus.hits_count), 16'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 11'd5);
        chk("hit_outside_flight", 16'(bus.hits_count), 16'd2);
        frames(6, 1'b0, 11'd450);

        // Drain the magazine, then automatic reload.
        for (int i = 0; i < 4; i++) begin
            shoot(1'b0, 11'd450);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd5);
            if (i < 3) frames(6, 1'b0, 11'd450);
        end
        chk("drain_ammo", 16'(bus.ammo), 16'd0);
        frames(5, 1'b0, 11'd450);
        chk("cd5_reloading", 16'(bus.reloading), 16'd0);
        frames(1, 1'b0, 11'd450);
        chk("cd6_reloading", 16'(bus.reloading), 16'd1);
        frames(29, 1'b0, 11'd450);
        chk("rl29_reloading", 16'(bus.reloading), 16'd1);
        chk("rl29_ammo", 16'(bus.ammo), 16'd0);
        frames(1, 1'b0, 11'd450);
        m_ammo = 8;
        chk("rl30_reloading", 16'(bus.reloading), 16'd0);
        chk("rl30_ammo", 16'(bus.ammo), 16'd8);

        // Manual reload from ammo 3.
        for (int i = 0; i < 5; i++) begin
            shoot(1'b0, 11'd450);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd5);
            frames(6, 1'b0, 11'd450);
        end
        chk("man_ammo3", 16'(bus.ammo), 16'd3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 11'd450);
        chk("man_reloading", 16'(bus.reloading), 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd450);
        frames(29, 1'b0, 11'd450);
        chk("man_rl29", 16'(bus.reloading), 16'd1);
        frames(1, 1'b0, 11'd450);
        m_ammo = 8;
        chk("man_rl30_reloading", 16'(bus.reloading), 16'd0);
        chk("man_rl30_ammo", 16'(bus.ammo), 16'd8);

        // Reload request on a full magazine is ignored; simultaneous rises launch.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 11'd450);
        chk("full_reload_ignored", 16'(bus.reloading), 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd450);
        shoot(1'b1, 11'd450);
        chk("both_ammo", 16'(bus.ammo), 16'd7);

        // Flight timeout.
        frames(63, 1'b0, 11'd450);
        chk("to63_active", 16'(bus.missile_active), 16'd1);
        frames(1, 1'b0, 11'd450);
        chk("to64_active", 16'(bus.missile_active), 16'd0);
        frames(6, 1'b0, 11'd450);

        // Reset mid-flight.
        shoot(1'b0, 11'd450);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd450);
        reset = 1'b0;
        chk("midrst_active", 16'(bus.missile_active), 16'd0);
        chk("midrst_fire", 16'(bus.fire), 16'd0);
        chk("midrst_ammo", 16'(bus.ammo), 16'd8);
        chk("midrst_hits", 16'(bus.hits_count), 16'd0);
        chk("midrst_reloading", 16'(bus.reloading), 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'd450);

        chk("sb_pending", 16'(shot_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fire_control.md
# fire_control

Player-side weapon controller driving the missile mover's `fire`/`hit` interface from the other end. Turns the raw keyboard fire key into single-cycle `fire` launch pulses and tracks the missile in flight until it hits or leaves the screen. Enforces one missile in flight, a magazine, a cooldown and a timed reload. Sits between the keyboard decoder, the collision detector and the missile mover.

## Interface
Parameters:
- `MAGAZINE`, 8: missiles per full magazine (1..15)
- `COOLDOWN_FRAMES`, 6: frames after a missile ends before the next launch
- `RELOAD_FRAMES`, 30: frames to refill an empty magazine
- `FLIGHT_TIMEOUT_FRAMES`, 64: safety limit on one flight
- `TOP_LIMIT`, 5: missile Y at or below which the missile is lost

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `startOfFrame`  in  1  one-cycle pulse per video frame
- `fire_key`  in  1  level from keyboard, high while pressed
- `reload_key`  in  1  level from keyboard, manual reload request
- `hit`  in  1  from collision detector: missile touched target
- `missileTopLeftY`  in  11  current missile Y from the missile mover
- `fire`  out  1  one-cycle launch pulse to the missile mover
- `missile_active`  out  1  high while a missile is in flight
- `ammo`  out  4  missiles remaining
- `reloading`  out  1  high in RELOAD
- `hits_count`  out  8  hits scored, saturating

## Operation
- Keys are registered each cycle into `fire_d` and `reload_d`.
- A rise is `key & ~key_d`. Only the rising edge acts; holding a key never auto-fires.
- State machine: READY, IN_FLIGHT, COOLDOWN, RELOAD.
- **READY**
  - If a fire rise occurs and `ammo > 0`: `fire` is high for the next cycle only, `ammo` decrements, go to IN_FLIGHT.
  - If a fire rise occurs and `ammo == 0`: go to RELOAD.
  - If a reload rise occurs and `ammo < MAGAZINE`: go to RELOAD.
  - If both rises occur in the same cycle, fire wins.
- **IN_FLIGHT**
  - `missile_active` is high.
  - `hit` causes `hits_count` +1 (saturates at 255), then go to COOLDOWN.
  - Missile lost: from the second cycle of IN_FLIGHT onward, `missileTopLeftY <= TOP_LIMIT` goes to COOLDOWN.
  - Timeout: `FLIGHT_TIMEOUT_FRAMES` `startOfFrame` pulses go to COOLDOWN.
  - If hit and lost occur in the same cycle, the hit is counted.
  - Key rises are ignored.
- **COOLDOWN**
  - Count `COOLDOWN_FRAMES` `startOfFrame` pulses.
  - Then go to RELOAD if `ammo == 0`, else to READY.
  - Key rises are ignored, not queued.
- **RELOAD**
  - `reloading` is high.
  - Count `RELOAD_FRAMES` pulses, then set `ammo = MAGAZINE` and go to READY.
- `hit` outside IN_FLIGHT is ignored.
- Frame counter: cleared on every state entry, advanced only on `startOfFrame`, terminal at `count == N-1` with a pulse present. A parameter of 0 is treated as 1.

## Timing
- Reset (synchronous, checked at the rising edge):
  - state READY, `ammo = MAGAZINE`, `hits_count = 0`
  - `fire = 0`, `missile_active = 0`, `reloading = 0`
  - `fire_d = 0`, `reload_d = 0`, counter 0
- All outputs are registered.
- Fire latency:
  - `fire_key` first sampled high at edge N (with `fire_d` low): `fire`, `missile_active` and the new `ammo` become visible after edge N.
  - The missile mover sees `fire` for exactly one clock.
- Hit latency: `hit` sampled at edge N gives the `hits_count` update and `missile_active` low after edge N.
- A key pressed during COOLDOWN and still held at READY entry does not fire; a fresh rise is required.
- Reset mid-flight aborts the flight immediately; `missile_active` drops and the magazine is refilled.

## Structure
- `fire_control_pkg`:
  - `fc_state_t` enum {READY, IN_FLIGHT, COOLDOWN, RELOAD}
  - `HITS_MAX = 255`
  - width constants: `AMMO_W = 4`, `Y_W = 11`
- Sub-module `frame_timer`:
  - inputs: clk, reset, clear, startOfFrame, terminal value
  - output: one-cycle `done`
  - used once, reloaded per state with COOLDOWN, RELOAD or TIMEOUT frames.

## Test plan
- Reset, then `fire_key` rise with Y=450 → `fire` high for 1 cycle, `ammo` 8→7, `missile_active=1`.
- In flight, hold `fire_key` and pulse it again → no `fire`; `hit` → `hits_count=1`, after 6 frames READY.
- Y steps from 450 to 5 with no hit → COOLDOWN, `hits_count` unchanged; `hit` and Y=5 in the same cycle → `hits_count` +1 exactly once.
- Fire 8 times with the missile lost each time → after the 8th cooldown `reloading=1`; after 30 frames `ammo=8`, READY.
- `ammo=3`, `reload_key` rise → RELOAD, `ammo=8` after 30 frames; both key rises in the same cycle → fire wins.
- Y held at 450 with no hit → timeout after 64 frames; assert `reset` mid-flight → all outputs at their reset values on the next cycle.
